des_key_sched_rev: RTL and testbench

DES_KEY_SCHED_REV -- requirements
Module: des_key_sched_rev

---
 rtl/des_key_sched_rev.sv | 165 ++++++++++++++++
 tb/tb_des_key_sched_rev.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_key_sched_rev.sv
// DES key schedule generator: emits the 16 round subkeys over a valid/ready
// handshake, in decryption order (K16..K1) or encryption order (K1..K16).
module des_key_sched_rev #(
  parameter bit DECRYPT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key_in,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round,
  output logic        busy,
  output logic        done
);

  localparam int unsigned KEY_W      = 64;
  localparam int unsigned HALF_W     = 28;
  localparam int unsigned CD_W       = 56;
  localparam int unsigned SK_W       = 48;
  localparam int unsigned RND_W      = 4;
  localparam int unsigned LAST_ROUND = 15;

  localparam int PC1 [CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2 [SK_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef enum logic {IDLE, RUN} state_t;

  state_t              state_q, state_d;
  logic [HALF_W-1:0]   c_q, c_d, d_q, d_d;
  logic [RND_W-1:0]    round_q, round_d;
  logic [SK_W-1:0]     subkey_q, subkey_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CD_W-1:0]     cd_load;
  logic [1:0]          adv_amt;
  logic [HALF_W-1:0]   c_adv, d_adv;
  logic [RND_W-1:0]    round_inc;

  function automatic logic [1:0] rot_amt(input logic [RND_W-1:0] r);
    case (r)
      4'd0:              rot_amt = DECRYPT ? 2'd0 : 2'd1;
      4'd1, 4'd8, 4'd15: rot_amt = 2'd1;
      default:           rot_amt = 2'd2;
    endcase
  endfunction

  function automatic logic [HALF_W-1:0] rot(input logic [HALF_W-1:0] x, input logic [1:0] n);
    case (n)
      2'd1:    rot = DECRYPT ? {x[0], x[27:1]}   : {x[26:0], x[27]};
      2'd2:    rot = DECRYPT ? {x[1:0], x[27:2]} : {x[25:0], x[27:26]};
      default: rot = x;
    endcase
  endfunction

  function automatic logic [CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [CD_W-1:0] res;
    res = '0;
    for (int i = 0; i < int'(CD_W); i++) res[6'(CD_W - 1 - i)] = k[6'(KEY_W - PC1[i])];
    return res;
  endfunction

  function automatic logic [SK_W-1:0] pc2(input logic [HALF_W-1:0] c, input logic [HALF_W-1:0] d);
    logic [CD_W-1:0] cd;
    logic [SK_W-1:0] res;
    cd  = {c, d};
    res = '0;
    for (int i = 0; i < int'(SK_W); i++) res[6'(SK_W - 1 - i)] = cd[6'(CD_W - PC2[i])];
    return res;
  endfunction

  // The last decrypt step commits one extra place so C,D end on the loaded key (total 28).
  assign adv_amt   = (DECRYPT && (round_q == RND_W'(LAST_ROUND))) ? 2'd2 : rot_amt(round_q);
  assign cd_load   = pc1(key_in);
  assign c_adv     = rot(c_q, adv_amt);
  assign d_adv     = rot(d_q, adv_amt);
  assign round_inc = round_q + 4'd1;

  always_comb begin
    state_d  = state_q;
    c_d      = c_q;
    d_d      = d_q;
    round_d  = round_q;
    subkey_d = subkey_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        valid_d  = 1'b0;
        busy_d   = 1'b0;
        subkey_d = '0;
        round_d  = '0;
        if (start) begin
          state_d  = RUN;
          c_d      = cd_load[55:28];
          d_d      = cd_load[27:0];
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          subkey_d = pc2(rot(cd_load[55:28], rot_amt(4'd0)), rot(cd_load[27:0], rot_amt(4'd0)));
        end
      end
      RUN: begin
        if (subkey_ready) begin
          c_d = c_adv;
          d_d = d_adv;
          if (round_q == RND_W'(LAST_ROUND)) begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            round_d  = '0;
            subkey_d = '0;
          end else begin
            round_d  = round_inc;
            subkey_d = pc2(rot(c_adv, rot_amt(round_inc)), rot(d_adv, rot_amt(round_inc)));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      c_q      <= '0;
      d_q      <= '0;
      round_q  <= '0;
      subkey_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      c_q      <= c_d;
      d_q      <= d_d;
      round_q  <= round_d;
      subkey_q <= subkey_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign subkey       = subkey_q;
  assign subkey_valid = valid_q;
  assign round        = round_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_des_key_sched_rev.sv
// Scoreboard bench for des_key_sched_rev: decrypt- and encrypt-order instances
// share stimulus; a textbook DES key schedule model supplies the expected subkeys.
module tb_des_key_sched_rev;

  typedef struct packed {
    logic [3:0]  rnd;
    logic [47:0] sk;
  } exp_t;

  localparam logic [63:0] GOLD_KEY = 64'h133457799BBCDFF1;

  logic        clk = 1'b0;
  logic        rst, start, subkey_ready;
  logic [63:0] key_in;
  logic [47:0] sk_d, sk_e;
  logic        v_d, v_e, b_d, b_e, dn_d, dn_e;
  logic [3:0]  r_d, r_e;

  int tests = 0;
  int fails = 0;

  exp_t qd[$];
  exp_t qe[$];
  bit   exp_done [2];
  bit   prev_v   [2];
  int   wait_cnt [2];
  bit   rand_rdy = 1'b0;

  int pc1_t [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                     63,55,47,39,31,23,15,7,62,54,46,38,30,22,14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int pc2_t [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,23,19,12,4,26,8,16,7,27,20,13,2,
                     41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  int sh_t  [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  logic [47:0] kref [16];

  always #5 clk = ~clk;

  des_key_sched_rev #(.DECRYPT(1'b1)) u_dec (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .subkey_ready(subkey_ready),
    .subkey(sk_d), .subkey_valid(v_d), .round(r_d), .busy(b_d), .done(dn_d)
  );

  des_key_sched_rev #(.DECRYPT(1'b0)) u_enc (
    .clk(clk), .rst(rst), .start(start), .key_in(key_in), .subkey_ready(subkey_ready),
    .subkey(sk_e), .subkey_valid(v_e), .round(r_e), .busy(b_e), .done(dn_e)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] rotl(input logic [27:0] x, input int s);
    logic [55:0] y;
    y = {x, x};
    return y[6'(55 - s) -: 28];
  endfunction

  // Standard encryption schedule K1..K16 into kref[0..15].
  task automatic build_ref(input logic [63:0] k);
    logic [55:0] cd;
    logic [55:0] x;
    logic [27:0] c, d;
    for (int j = 0; j < 56; j++) cd[6'(55 - j)] = k[6'(64 - pc1_t[j])];
    c = cd[55:28];
    d = cd[27:0];
    for (int i = 0; i < 16; i++) begin
      c = rotl(c, sh_t[i]);
      d = rotl(d, sh_t[i]);
      x = {c, d};
      for (int b = 0; b < 48; b++) kref[4'(i)][6'(47 - b)] = x[6'(56 - pc2_t[b])];
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller must be just after a rising edge in a cycle where the DUT is idle.
  task automatic do_start(input logic [63:0] k);
    exp_t e;
    key_in = k;
    start  = 1'b1;
    build_ref(k);
    for (int r = 0; r < 16; r++) begin
      e.rnd = 4'(r);
      e.sk  = kref[4'(15 - r)];
      qd.push_back(e);
      e.sk  = kref[4'(r)];
      qe.push_back(e);
    end
    tick(1);
    start  = 1'b0;
    key_in = {$urandom, $urandom};
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((qd.size() != 0 || qe.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    if (n >= budget) chk("drain_timeout", 64'(qd.size() + qe.size()), 64'd0);
  endtask

  task automatic wait_rd(input logic [3:0] tr);
    int n = 0;
    while (!(v_d && r_d == tr) && n < 60) begin
      tick(1);
      n++;
    end
    if (n >= 60) chk("wait_round", 64'(r_d), 64'(tr));
  endtask

  task automatic flush();
    qd.delete();
    qe.delete();
    for (int i = 0; i < 2; i++) begin
      exp_done[i] = 1'b0;
      prev_v[i]   = 1'b0;
      wait_cnt[i] = 0;
    end
  endtask

  task automatic mon(input int id, input logic v, input logic [47:0] sk, input logic [3:0] r,
                     input logic b, input logic dn);
    exp_t e;
    int   qs;
    qs = (id == 0) ? qd.size() : qe.size();
    if (exp_done[id]) begin
      chk($sformatf("done[%0d]", id), 64'({dn, v, b, r}), 64'({1'b1, 1'b0, 1'b0, 4'd0}));
      exp_done[id] = 1'b0;
    end
    if (!v) begin
      chk($sformatf("idle_zero[%0d]", id), 64'(sk), 64'd0);
      prev_v[id] = 1'b0;
      if (qs != 0) begin
        wait_cnt[id]++;
        if (wait_cnt[id] > 20) begin
          chk($sformatf("valid_timeout[%0d]", id), 64'(wait_cnt[id]), 64'd0);
          flush();
        end
      end
    end else if (qs == 0) begin
      chk($sformatf("unexpected[%0d]", id), 64'(v), 64'd0);
      prev_v[id] = 1'b1;
    end else begin
      e = (id == 0) ? qd[0] : qe[0];
      if (!prev_v[id] && e.rnd == 4'd0)
        chk($sformatf("latency[%0d]", id), 64'(wait_cnt[id]), 64'd1);
      wait_cnt[id] = 0;
      prev_v[id]   = 1'b1;
      chk($sformatf("subkey[%0d] r%0d", id, e.rnd), 64'({b, r, sk}), 64'({1'b1, e.rnd, e.sk}));
      if (subkey_ready) begin
        if (id == 0) void'(qd.pop_front());
        else         void'(qe.pop_front());
        if (e.rnd == 4'd15) exp_done[id] = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, v_d, sk_d, r_d, b_d, dn_d);
      mon(1, v_e, sk_e, r_e, b_e, dn_e);
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rand_rdy) subkey_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0;
    subkey_ready = 1'b0;
    key_in = '0;
    flush();
    tick(2);
    chk("reset_dec", 64'({sk_d, v_d, r_d, b_d, dn_d}), 64'd0);
    chk("reset_enc", 64'({sk_e, v_e, r_e, b_e, dn_e}), 64'd0);
    rst = 1'b0;
    tick(2);

    // Known-answer schedule with a consumer that is always ready.
    subkey_ready = 1'b1;
    do_start(GOLD_KEY);
    @(negedge clk);
    chk("gold_first_dec", 64'({r_d, sk_d}), 64'({4'd0, 48'hCB3D8B0E17F5}));
    chk("gold_first_enc", 64'({r_e, sk_e}), 64'({4'd0, 48'h1B02EFFC7072}));
    repeat (15) @(negedge clk);
    chk("gold_last_dec", 64'({r_d, sk_d}), 64'({4'd15, 48'h1B02EFFC7072}));
    chk("gold_last_enc", 64'({r_e, sk_e}), 64'({4'd15, 48'hCB3D8B0E17F5}));
    tick(1);
    wait_drain(100);

    // Degenerate keys, the second started in the done cycle of the first.
    tick(2);
    do_start(64'h0000000000000000);
    wait_drain(100);
    do_start(64'hFFFFFFFFFFFFFFFF);
    wait_drain(100);
    tick(3);

    // Consumer stalls for 5 cycles at round 3.
    do_start(GOLD_KEY);
    wait_rd(4'd3);
    subkey_ready = 1'b0;
    tick(5);
    subkey_ready = 1'b1;
    wait_drain(100);
    tick(3);

    // A start mid-schedule with another key must be ignored.
    do_start(GOLD_KEY);
    wait_rd(4'd7);
    start  = 1'b1;
    key_in = 64'h0123456789ABCDEF;
    tick(1);
    start  = 1'b0;
    wait_drain(100);
    tick(3);

    // Asynchronous reset mid-schedule aborts; restart reproduces the schedule.
    do_start(GOLD_KEY);
    wait_rd(4'd9);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_dec", 64'({sk_d, v_d, r_d, b_d, dn_d}), 64'd0);
    chk("async_rst_enc", 64'({sk_e, v_e, r_e, b_e, dn_e}), 64'd0);
    flush();
    @(posedge clk);
    #3 rst = 1'b0;
    tick(6);
    do_start(GOLD_KEY);
    wait_drain(100);
    tick(3);

    // Random keys, random backpressure and random gaps (including back-to-back).
    rand_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick($urandom_range(0, 3));
      do_start({$urandom, $urandom});
      wait_drain(400);
    end
    rand_rdy = 1'b0;
    subkey_ready = 1'b1;
    tick(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
